left_shift_x16_seq: RTL and testbench

LEFT_SHIFT_X16_SEQ -- requirements
Module: left_shift_x16_seq

---
 rtl/ml_acc_pkg.sv | 18 +
 rtl/shift_cnt.sv | 48 ++++
 rtl/left_shift_x16_seq.sv | 103 ++++++++++
 tb/tb_left_shift_x16_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ml_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ml_acc_pkg : shared state type and default datapath width for the         |
// |              sequential left shifter.                                     |
// | Revision   : 1.0                                                          |
// +----------------------------------------------------------------------------+
package ml_acc_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_cnt : shift-count register. Clamps the requested amount to WIDTH,   |
// |             decrements once per shift, and flags zero / last-shift.        |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
module shift_cnt #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last,
  output logic             load_zero
);

  localparam logic [WIDTH-1:0] c_limit     = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    c_limit_cnt = CW'(WIDTH);
  localparam logic [CW-1:0]    c_one       = CW'(1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_clamped;

  // Any amount of WIDTH or more shifts everything out, so WIDTH cycles suffice.
  always_comb begin
    w_clamped = (load_val >= c_limit) ? c_limit_cnt : load_val[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= w_clamped;
    end else if (dec) begin
      r_count <= r_count - c_one;
    end
  end

  assign zero      = (r_count == '0);
  assign last      = (r_count == c_one);
  assign load_zero = (w_clamped == '0);

endmodule
`default_nettype wire

// File: rtl/left_shift_x16_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | left_shift_x16_seq : one-bit-per-cycle left shifter with valid/ready      |
// |                      handshakes. Optional overflow flag: LSHIFT_OVF_EN.    |
// | Revision           : 1.0                                                  |
// +----------------------------------------------------------------------------+
module left_shift_x16_seq
  import ml_acc_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;
  logic             w_shift;
  logic             w_cnt_zero;
  logic             w_cnt_last;
  logic             w_load_zero;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_shift  = (r_state == SHIFT);

  shift_cnt #(
    .WIDTH (WIDTH)
  ) u_shift_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_accept),
    .load_val  (b),
    .dec       (w_shift && !w_cnt_zero),
    .zero      (w_cnt_zero),
    .last      (w_cnt_last),
    .load_zero (w_load_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_load_zero ? DONE : SHIFT;
      SHIFT:   if (w_cnt_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_accept) begin
      r_data <= a;
    end else if (w_shift) begin
      r_data <= r_data << 1;
    end
  end

`ifdef LSHIFT_OVF_EN
  logic r_ovf;

  // Sticky: the MSB about to leave on this shift carries a lost set bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_shift && r_data[WIDTH-1]) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out       = r_data;

endmodule
`default_nettype wire

// File: tb/tb_left_shift_x16_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_left_shift_x16_seq : self-checking bench for left_shift_x16_seq.       |
// | Revision              : 1.0                                               |
// +----------------------------------------------------------------------------+
module tb_left_shift_x16_seq;

`ifdef LSHIFT_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  left_shift_x16_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an op occupies min(b,16)+1 edges, result is plain arithmetic.
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  int          m_rem = 0;
  logic [15:0] m_res = '0;
  logic        m_ovf = 1'b0;
  int          m_done = 0;
  int          bc;
  logic [31:0] wide;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_rem   <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        bc      = (b >= 16'd16) ? 16 : int'(b);
        wide    = {16'h0, a} << bc;
        m_res   <= wide[15:0];
        m_ovf   <= OVF_ON && (wide[31:16] != 16'h0);
        m_rem   <= bc;
        m_busy  <= 1'b1;
        m_valid <= (bc == 0);
      end
    end else if (!m_valid) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) m_valid <= 1'b1;
    end else if (out_ready) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_done  <= m_done + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_out", {16'h0, out}, 32'h0);
      chk("rst_ovf", {31'h0, ovf}, 32'h0);
    end else begin
      chk("in_ready", {31'h0, in_ready}, {31'h0, !m_busy});
      chk("busy", {31'h0, busy}, {31'h0, m_busy});
      chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
      if (m_valid) begin
        chk("out", {16'h0, out}, {16'h0, m_res});
        chk("ovf", {31'h0, ovf}, {31'h0, m_ovf});
      end
    end
  end

  // Directed op with literal expectations. Called and returned on a negedge.
  task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb_b,
                        input int hold, input bit junk, input logic [15:0] exp_out,
                        input logic exp_ovf, input int exp_lat);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk({name, "_ready_timeout"}, 32'h0, 32'h1);
      return;
    end
    in_valid = 1'b1;
    a = ta;
    b = tb_b;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (junk) begin
        in_valid = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) break;
      chk({name, "_busy_wait"}, {31'h0, busy}, 32'h1);
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_out"}, {16'h0, out}, {16'h0, exp_out});
    chk({name, "_ovf"}, {31'h0, ovf}, {31'h0, exp_ovf});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, {31'h0, out_valid}, 32'h1);
      chk({name, "_hold_out"}, {16'h0, out}, {16'h0, exp_out});
    end
    out_ready = 1'b1;
    if (junk) begin
      a = 16'h0005;
      b = 16'h0003;
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_idle_ready"}, {31'h0, in_ready}, 32'h1);
    chk({name, "_idle_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);

    run_op("b0", 16'h0001, 16'h0000, 0, 1'b0, 16'h0001, 1'b0, 1);
    run_op("b15", 16'h0001, 16'h000F, 0, 1'b0, 16'h8000, 1'b0, 16);
    run_op("b16", 16'hFFFF, 16'h0010, 0, 1'b0, 16'h0000, OVF_ON, 17);
    run_op("bffff", 16'hFFFF, 16'hFFFF, 0, 1'b0, 16'h0000, OVF_ON, 17);
    run_op("hold5", 16'h8001, 16'h0001, 5, 1'b0, 16'h0002, OVF_ON, 2);

    // Reset pulse on the third shift cycle of a=3,b=8.
    in_valid = 1'b1;
    a = 16'h0003;
    b = 16'h0008;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_out", {16'h0, out}, 32'h0);
    chk("midrst_ovf", {31'h0, ovf}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", {31'h0, in_ready}, 32'h1);
    run_op("after_rst", 16'h0003, 16'h0002, 0, 1'b0, 16'h000C, 1'b0, 3);

    // Junk on in_valid while busy; the next pair is taken after one IDLE cycle.
    run_op("junk", 16'h0101, 16'h0004, 2, 1'b1, 16'h1010, 1'b0, 5);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_busy", {31'h0, busy}, 32'h1);
    chk("b2b_in_ready", {31'h0, in_ready}, 32'h0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_latency", lat, 4);
    chk("b2b_out", {16'h0, out}, 32'h0028);
    chk("b2b_ovf", {31'h0, ovf}, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      a         = 16'($urandom);
      b         = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("random_ops_completed", {31'h0, (m_done > 50)}, 32'h1);
    chk("drain_idle", {31'h0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
